// File: rtl/fact_pkg.sv
// Shared types and constants for the fact_sched factorial engine.
package fact_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  localparam int NUM_W_DEF   = 8;
  localparam int RES_W_DEF   = 32;
  localparam int MAX_EXACT_N = 12;

  localparam logic [31:0] FACT_12       = 32'd479001600;
  localparam logic [31:0] FACT_13_TRUNC = 32'h7328CC00;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: cyclic first-valid search starting at ptr_q.
// The pointer moves past the winner whenever upd is pulsed.
module rr_arbiter
  import fact_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] gnt_id
);
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              idx;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = ID_W'((int'(gnt_id) + 1) % NREQ);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fact_sched.sv
// Time-shared iterative factorial engine behind a round-robin arbiter.
// FACT_EARLY_OVF_EN: stop at the first overflow and saturate the result.
module fact_sched
  import fact_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int NUM_W = NUM_W_DEF,
  parameter  int RES_W = RES_W_DEF,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*NUM_W-1:0] req_num,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_ovf,
  output logic              busy
);
  state_e           state_q, state_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [NREQ-1:0]  grant;
  logic [ID_W-1:0]  gnt_id;
  logic             accept;
  logic             arb_en;
  logic [RES_W+NUM_W-1:0] prod;
  logic             prod_hi;

  assign arb_en = (state_q == IDLE) && !rst;
  assign accept = |grant;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en),
    .req    (req_valid),
    .upd    (accept),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign prod    = {{NUM_W{1'b0}}, acc_q} * {{RES_W{1'b0}}, cnt_q};
  assign prod_hi = |prod[RES_W+NUM_W-1:RES_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = req_num[gnt_id*NUM_W +: NUM_W];
          id_d    = gnt_id;
          acc_d   = RES_W'(1);
          ovf_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q <= NUM_W'(1)) begin
          state_d = RESP;
        end else begin
`ifdef FACT_EARLY_OVF_EN
          if (prod_hi) begin
            acc_d   = '1;
            ovf_d   = 1'b1;
            state_d = RESP;
          end else begin
            acc_d = prod[RES_W-1:0];
            cnt_d = cnt_q - 1'b1;
          end
`else
          acc_d = prod[RES_W-1:0];
          ovf_d = ovf_q | prod_hi;
          cnt_d = cnt_q - 1'b1;
`endif
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = acc_q;
  assign rsp_ovf    = ovf_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_fact_sched.sv
// Scoreboard bench for fact_sched: random and directed requests
// checked against an arithmetic factorial / round-robin model.
module tb_fact_sched;
  import fact_pkg::*;

  localparam int NREQ  = 4;
  localparam int NUM_W = 8;
  localparam int RES_W = 32;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*NUM_W-1:0] req_num;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [RES_W-1:0]      rsp_result;
  logic                  rsp_ovf;
  logic                  busy;

  fact_sched #(.NREQ(NREQ), .NUM_W(NUM_W), .RES_W(RES_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_num    (req_num),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        ovf;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ptr_m = 0;
  int          hs_next = -1;
  bit          in_resp = 1'b0;
  bit          rst_prev = 1'b0;
  logic [ID_W-1:0] h_id;
  logic [31:0] h_res;
  logic        h_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // N! mod 2^32, true-overflow flag and accept-to-valid latency
  task automatic model(input int n, output logic [31:0] res,
                       output logic ovf, output int lat);
    logic [63:0]     t;
    longint unsigned ex;
    int              j;
    res = 32'd1;
    ovf = 1'b0;
    ex  = 1;
    for (int i = 2; i <= n; i++) begin
      t   = {32'd0, res} * 64'(i);
      res = t[31:0];
      if (!ovf) begin
        ex = ex * longint'(i);
        if (ex > 64'hFFFF_FFFF) ovf = 1'b1;
      end
    end
    lat = 1 + ((n < 1) ? 1 : n);
`ifdef FACT_EARLY_OVF_EN
    if (ovf) begin
      res = '1;
      ex  = 1;
      j   = 0;
      for (int i = n; i >= 2; i--) begin
        j++;
        ex = ex * longint'(i);
        if (ex > 64'hFFFF_FFFF) begin
          lat = 1 + j;
          break;
        end
      end
    end
`else
    j = 0;
`endif
  endtask

  always @(negedge clk) begin
    exp_t            e;
    logic [NREQ-1:0] eg;
    int              k;
    if (rst) begin
      sb.delete();
      in_resp  = 1'b0;
      hs_next  = -1;
      ptr_m    = 0;
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_rsp_id", 64'(rsp_id), 0);
        check("rst_rsp_result", 64'(rsp_result), 0);
        check("rst_rsp_ovf", 64'(rsp_ovf), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_req_ready", 64'(req_ready), 0);
        rst_prev = 1'b0;
      end
      if (req_ready != '0) begin
        k = -1;
        for (int i = 0; i < NREQ; i++)
          if (k < 0 && req_valid[(ptr_m + i) % NREQ])
            k = (ptr_m + i) % NREQ;
        eg = '0;
        if (k >= 0) eg[k] = 1'b1;
        check("grant", 64'(req_ready), 64'(eg));
        if (hs_next >= 0) begin
          check("bubble", 64'(cyc), 64'(hs_next));
          hs_next = -1;
        end
        for (int j = 0; j < NREQ; j++) begin
          if (req_valid[j] && req_ready[j]) begin
            e.id = j;
            model(int'(req_num[j*NUM_W +: NUM_W]), e.res, e.ovf, e.lat);
            e.acc_cyc = cyc;
            sb.push_back(e);
          end
        end
        if (k >= 0) ptr_m = (k + 1) % NREQ;
      end
      if (rsp_valid) begin
        check("resp_req_ready", 64'(req_ready), 0);
        check("resp_busy", 64'(busy), 1);
        if (!in_resp) begin
          in_resp = 1'b1;
          h_id    = rsp_id;
          h_res   = rsp_result;
          h_ovf   = rsp_ovf;
          if (sb.size() == 0)
            check("spurious_rsp", 64'(sb.size()), 1);
          else
            check("latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
        end else begin
          check("hold_id", 64'(rsp_id), 64'(h_id));
          check("hold_result", 64'(rsp_result), 64'(h_res));
          check("hold_ovf", 64'(rsp_ovf), 64'(h_ovf));
        end
        if (rsp_ready) begin
          in_resp = 1'b0;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_result", 64'(rsp_result), 64'(e.res));
            check("rsp_ovf", 64'(rsp_ovf), 64'(e.ovf));
          end
          hs_next = (req_valid != '0) ? cyc + 1 : -1;
        end
      end
    end
  end

  // advance one cycle; drop requests that were granted this cycle
  task automatic tick();
    logic [NREQ-1:0] g;
    @(negedge clk);
    g = rst ? '0 : (req_valid & req_ready);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic issue(input int k, input int n);
    req_num[k*NUM_W +: NUM_W] = NUM_W'(n);
    req_valid[k] = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0 || in_resp) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_timeout", 64'(n < 3000), 1);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_num   = '0;
    rsp_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    issue(0, 5);  drain();
    issue(1, 0);  drain();
    issue(2, 1);  drain();
    issue(2, 12); drain();
    issue(3, 13); drain();

    repeat (2) begin
      issue(0, 3); issue(1, 4); issue(2, 5); issue(3, 6);
      drain();
    end

    rsp_ready = 1'b0;
    issue(1, 4);
    tick();
    issue(2, 7);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check("stall_wait", 64'(rsp_valid), 1);
    repeat (5) tick();
    rsp_ready = 1'b1;
    drain();

    issue(0, 10);
    repeat (4) tick();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    issue(0, 2); issue(1, 8); issue(2, 255); issue(3, 20);
    drain();

    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] && $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 199) == 0)
            issue(k, 255);
          else if ($urandom_range(0, 3) == 0)
            issue(k, int'($urandom_range(MAX_EXACT_N + 1, 40)));
          else
            issue(k, int'($urandom_range(0, MAX_EXACT_N + 2)));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
